// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES inverse cipher: FSM state encoding,
// round-count constants, block width and the GF(2^8) helpers used by the
// inverse-round datapath.
package aes_dec_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam int BLK_W  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exponent 254: a^254 is the multiplicative inverse of a in GF(2^8), 0 -> 0.
  localparam logic [7:0] GF_INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (GF_INV_EXP[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine transform, then take the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/inv_cipher_ctrl_inv_round.sv
// Combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey
// -> InvMixColumns, with the column mix bypassed for the last round.
// Byte k of a block sits in [127-8k -: 8]; state[r][c] is byte r+4c.

module InvShiftRows
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);
  // Row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_data[127-8*(r+4*c) -: 8] = i_data[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end
endmodule

module InvSubBytes
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);
  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign o_data[127-8*k -: 8] = inv_sbox(i_data[127-8*k -: 8]);
  end
endmodule

module AddRoundKey
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  input  logic [BLK_W-1:0] i_key,
  output logic [BLK_W-1:0] o_data
);
  assign o_data = i_data ^ i_key;
endmodule

module InvMixColumns
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);
  // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_data[127-32*c -: 8];
    assign w_a1 = i_data[119-32*c -: 8];
    assign w_a2 = i_data[111-32*c -: 8];
    assign w_a3 = i_data[103-32*c -: 8];
    assign o_data[127-32*c -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^
                                   gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
    assign o_data[119-32*c -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^
                                   gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
    assign o_data[111-32*c -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^
                                   gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
    assign o_data[103-32*c -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^
                                   gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
  end
endmodule

module inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_state,
  input  logic [BLK_W-1:0] i_key,
  input  logic             i_skip_mix,
  output logic [BLK_W-1:0] o_state
);
  logic [BLK_W-1:0] w_isr;
  logic [BLK_W-1:0] w_isb;
  logic [BLK_W-1:0] w_ark;
  logic [BLK_W-1:0] w_imc;

  InvShiftRows  u_isr (.i_data(i_state), .o_data(w_isr));
  InvSubBytes   u_isb (.i_data(w_isr),   .o_data(w_isb));
  AddRoundKey   u_ark (.i_data(w_isb),   .i_key(i_key), .o_data(w_ark));
  InvMixColumns u_imc (.i_data(w_ark),   .o_data(w_imc));

  assign o_state = i_skip_mix ? w_ark : w_imc;
endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per clock, NR
// rounds per block, external round-key store indexed by key_idx and read
// combinationally. Optional completed-block counter behind INV_CIPHER_CNT_EN.
//
// Handshakes: a beat transfers on a rising clk edge where valid & ready are
// both high. in_ready is high in IDLE, and in DONE it follows out_ready so a
// new block can be taken on the same edge the current plaintext is consumed.
// out_data is stable while out_valid is high and holds after it drops.
module inv_cipher_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_128
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic [3:0]       key_idx,
  input  logic [BLK_W-1:0] round_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
`ifdef INV_CIPHER_CNT_EN
  output logic [31:0]      blk_cnt,
`endif
  output state_t           dbg_state
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("inv_cipher_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_K  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  state_t           r_state;
  logic [3:0]       r_rnd;
  logic [3:0]       r_key_idx;
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_consume;
  logic             w_skip_mix;
  logic [3:0]       w_rnd_dec;
  logic [BLK_W-1:0] w_round_out;

  assign w_consume  = (r_state == DONE) && out_ready;
  assign in_ready   = (r_state == IDLE) || w_consume;
  assign w_skip_mix = (r_state == FINAL);
  // Saturating decrement: the round counter never wraps below zero.
  assign w_rnd_dec  = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;

  inv_round u_round (
    .i_state    (r_blk),
    .i_key      (round_key),
    .i_skip_mix (w_skip_mix),
    .o_state    (w_round_out)
  );

  // Control FSM: sequences the rounds and owns all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rnd       <= 4'd0;
      r_key_idx   <= NR_K;
      r_blk       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_blk     <= in_data ^ round_key;
            r_rnd     <= NR_M1;
            r_key_idx <= NR_M1;
            r_busy    <= 1'b1;
            r_state   <= ROUND;
          end
        end
        ROUND: begin
          r_blk     <= w_round_out;
          r_rnd     <= w_rnd_dec;
          r_key_idx <= w_rnd_dec;
          if (r_rnd == 4'd1) r_state <= FINAL;
        end
        FINAL: begin
          r_blk       <= w_round_out;
          r_out_data  <= w_round_out;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_key_idx   <= NR_K;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              // Chain straight into the next block; key_idx is already NR.
              r_blk     <= in_data ^ round_key;
              r_rnd     <= NR_M1;
              r_key_idx <= NR_M1;
              r_busy    <= 1'b1;
              r_state   <= ROUND;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INV_CIPHER_CNT_EN
  logic [31:0] r_blk_cnt;

  // Completed-block counter, stepped on every plaintext handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_blk_cnt <= 32'd0;
    else if (w_consume) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign key_idx   = r_key_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
